mult_share_arbiter: RTL and testbench

- Shares one unsigned 8x8 multiplier datapath among NUM_REQ requesters.
- Arbitration is round-robin with per-requester valid/ready handshakes.
- Operands pass through a 2-stage pipeline: operand register, then product register.
- Each result carries the ID of the requester that issued it.
- Sits between the DSP kernel clients and the shared multiplier resource.

---
 rtl/mult_share_arbiter.sv | 93 +++++++++
 tb/tb_mult_share_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter in front of one shared unsigned OP_W x OP_W multiplier.
// Two-stage pipe (operand reg, product reg); each result is tagged with its requester ID.
module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int OP_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*OP_W-1:0] req_a,
  input  logic [NUM_REQ*OP_W-1:0] req_b,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [2*OP_W-1:0]       resp_product,
  output logic                    busy
);

  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              s1_valid_q, s2_valid_q;
  logic [OP_W-1:0]   s1_a_q, s1_b_q;
  logic [ID_W-1:0]   s1_id_q, s2_id_q;
  logic [2*OP_W-1:0] s2_product_q, s2_product_d;

  logic              en;
  logic              found;
  logic              xfer;
  logic [ID_W-1:0]   win;
  logic [ID_W-1:0]   idx;
  logic [OP_W-1:0]   sel_a, sel_b;

  // The whole pipe moves only when the output slot is empty or being consumed.
  assign en = !s2_valid_q || resp_ready;

  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr_q + ID_W'(k);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign xfer  = found && en && !rst;
  assign sel_a = req_a[win*OP_W +: OP_W];
  assign sel_b = req_b[win*OP_W +: OP_W];
  assign ptr_d = xfer ? win + ID_W'(1) : ptr_q;

  always_comb begin
    req_ready = '0;
    if (xfer) begin
      req_ready[win] = 1'b1;
    end
  end

  assign s2_product_d = (2*OP_W)'(s1_a_q) * (2*OP_W)'(s1_b_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_id_q      <= '0;
      s2_valid_q   <= 1'b0;
      s2_id_q      <= '0;
      s2_product_q <= '0;
    end else if (en) begin
      ptr_q      <= ptr_d;
      s1_valid_q <= xfer;
      if (xfer) begin
        s1_a_q  <= sel_a;
        s1_b_q  <= sel_b;
        s1_id_q <= win;
      end
      s2_valid_q   <= s1_valid_q;
      s2_id_q      <= s1_id_q;
      s2_product_q <= s2_product_d;
    end
  end

  assign resp_valid   = s2_valid_q;
  assign resp_id      = s2_id_q;
  assign resp_product = s2_product_q;
  assign busy         = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized and directed bench for mult_share_arbiter: a round-robin/occupancy model
// predicts grants, and a scoreboard queue holds the expected {id, product} stream.
module tb_mult_share_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [N*8-1:0] req_a = '0;
  logic [N*8-1:0] req_b = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [1:0]    resp_id;
  logic [15:0]   resp_product;
  logic          busy;

  mult_share_arbiter #(.NUM_REQ(N), .ID_W(2), .OP_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_product(resp_product),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] prod;
  } exp_t;

  exp_t sbQ[$];
  int   vectors = 0;
  int   miscompares = 0;

  int   m_ptr = 0;
  bit   m_s1v = 1'b0;
  bit   m_s2v = 1'b0;
  bit   m_justReset = 1'b0;
  bit   grantHit = 1'b0;
  int   grantIdx = 0;

  bit       pend_v[N];
  bit [7:0] pend_a[N];
  bit [7:0] pend_b[N];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: predicts grant and occupancy from the arbitration rules, checks the
  // DUT against them, and pops the scoreboard whenever a result is consumed.
  always @(negedge clk) begin
    automatic logic [N-1:0] expReady = '0;
    automatic bit en;
    automatic bit hit = 1'b0;
    automatic int w = 0;
    automatic int j;
    automatic exp_t e;
    en = !m_s2v || resp_ready;
    if (!rst && en) begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (!hit && req_valid[j]) begin
          hit = 1'b1;
          w = j;
        end
      end
    end
    if (hit) expReady[w] = 1'b1;
    checkOutput("req_ready", 32'(req_ready), 32'(expReady));
    checkOutput("resp_valid", 32'(resp_valid), 32'(m_s2v));
    checkOutput("busy", 32'(busy), 32'(m_s1v || m_s2v));
    if (m_justReset) begin
      checkOutput("reset_id", 32'(resp_id), 32'd0);
      checkOutput("reset_product", 32'(resp_product), 32'd0);
    end
    if (m_s2v) begin
      if (sbQ.size() == 0) begin
        checkOutput("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        checkOutput("resp_id", 32'(resp_id), 32'(sbQ[0].id));
        checkOutput("resp_product", 32'(resp_product), 32'(sbQ[0].prod));
      end
    end
    if (rst) begin
      sbQ.delete();
      m_s1v = 1'b0;
      m_s2v = 1'b0;
      m_ptr = 0;
    end else if (en) begin
      if (m_s2v && sbQ.size() > 0) void'(sbQ.pop_front());
      m_s2v = m_s1v;
      m_s1v = hit;
      if (hit) begin
        e.id   = 2'(w);
        e.prod = 16'(int'(req_a[w*8 +: 8]) * int'(req_b[w*8 +: 8]));
        sbQ.push_back(e);
        m_ptr = (w + 1) % N;
      end
    end
    grantHit    = hit;
    grantIdx    = w;
    m_justReset = rst;
  end

  // Advance one cycle; a requester that was granted drops its request.
  task automatic nextCycle();
    @(posedge clk);
    #1;
    if (grantHit) pend_v[grantIdx] = 1'b0;
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      req_valid[i]      = pend_v[i];
      req_a[i*8 +: 8]   = pend_a[i];
      req_b[i*8 +: 8]   = pend_b[i];
    end
  endtask

  task automatic raise(input int i, input int a, input int b);
    pend_v[i] = 1'b1;
    pend_a[i] = 8'(a);
    pend_b[i] = 8'(b);
  endtask

  task automatic waitIdle();
    int n = 0;
    resp_ready = 1'b1;
    while ((pend_v[0] || pend_v[1] || pend_v[2] || pend_v[3] || m_s1v || m_s2v) && n < 60) begin
      applyStimulus();
      nextCycle();
      n++;
    end
    applyStimulus();
    if (n >= 60) checkOutput("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
    applyStimulus();
    nextCycle();
    rst = 1'b0;
    for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
    applyStimulus();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 1'b0;
      pend_a[i] = '0;
      pend_b[i] = '0;
    end
    rst = 1'b1;
    repeat (3) nextCycle();
    rst = 1'b0;
    applyStimulus();
    nextCycle();

    $display("[TB] single request");
    resp_ready = 1'b1;
    raise(0, 12, 13);
    applyStimulus();
    nextCycle();
    waitIdle();

    $display("[TB] all requesters streaming");
    for (int c = 0; c < 14; c++) begin
      for (int i = 0; i < N; i++) if (!pend_v[i]) raise(i, i + 1, 10);
      applyStimulus();
      nextCycle();
    end
    waitIdle();

    $display("[TB] backpressure");
    raise(1, 21, 3);
    raise(2, 100, 7);
    raise(3, 250, 11);
    for (int c = 0; c < 3; c++) begin
      applyStimulus();
      nextCycle();
    end
    resp_ready = 1'b0;
    raise(0, 9, 9);
    for (int c = 0; c < 5; c++) begin
      applyStimulus();
      nextCycle();
    end
    waitIdle();

    $display("[TB] extremes");
    raise(0, 255, 255);
    raise(1, 0, 200);
    raise(2, 1, 255);
    waitIdle();

    $display("[TB] fairness");
    for (int c = 0; c < 10; c++) begin
      if (!pend_v[2]) raise(2, 5, c + 1);
      if (c == 3) raise(0, 17, 4);
      applyStimulus();
      nextCycle();
    end
    waitIdle();

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend_v[i] && $urandom_range(0, 2) == 0)
          raise(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      resp_ready = ($urandom_range(0, 3) != 0);
      applyStimulus();
      nextCycle();
    end
    waitIdle();

    $display("[TB] reset mid-operation");
    raise(2, 30, 30);
    raise(3, 40, 40);
    applyStimulus();
    nextCycle();
    resp_ready = 1'b0;
    applyStimulus();
    nextCycle();
    pulseReset();
    nextCycle();
    resp_ready = 1'b1;
    raise(1, 7, 9);
    waitIdle();
    repeat (3) nextCycle();

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
